// File: rtl/dcache_uncached_bridge_pkg.sv
// Shared types and constants for the uncached dcache bridge.
// The optional same-word merge is enabled with DCACHE_BRIDGE_MERGE_EN.
package dcache_uncached_bridge_pkg;

    localparam int unsigned TagWidth    = 20;
    localparam int unsigned IndexWidth  = 6;
    localparam int unsigned OffsetWidth = 6;
    localparam int unsigned AddrWidth   = TagWidth + IndexWidth + OffsetWidth;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq0  = 3'd1,
        StWait0 = 3'd2,
        StReq1  = 3'd3,
        StWait1 = 3'd4,
        StDone  = 3'd5
    } dcache_bridge_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_slot_t;

    // Byte-wise merge: port-1 bytes win wherever port 1 strobes.
    function automatic logic [31:0] merge_wdata(input logic [31:0] wdata0,
                                                input logic [31:0] wdata1,
                                                input logic [3:0]  wstrb1);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = wstrb1[b] ? wdata1[8*b +: 8] : wdata0[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_bridge_slot_sel.sv
// Picks the slot currently presented on the memory bus and, when
// DCACHE_BRIDGE_MERGE_EN is defined, folds a same-word pair into one beat.
module dcache_bridge_slot_sel
    import dcache_uncached_bridge_pkg::*;
(
    input  mem_slot_t slot0,
    input  mem_slot_t slot1,
    input  logic      has_p1,
    input  logic      sel,
    output mem_slot_t active,
    output logic      merge
);

    mem_slot_t first;

`ifdef DCACHE_BRIDGE_MERGE_EN
    always_comb begin
        merge = has_p1 && (slot0.addr[31:2] == slot1.addr[31:2]);
        first = slot0;
        if (merge && slot0.we) begin
            first.wstrb = slot0.wstrb | slot1.wstrb;
            first.wdata = merge_wdata(slot0.wdata, slot1.wdata, slot1.wstrb);
            first.size  = 2'd2;
        end
    end
`else
    logic unused_has_p1;
    assign unused_has_p1 = has_p1;

    always_comb begin
        merge = 1'b0;
        first = slot0;
    end
`endif

    assign active = sel ? slot1 : first;

endmodule

// File: rtl/dcache_uncached_bridge.sv
// Serializes a dual-port dcache request pair into single-beat memory transactions.
// Optional same-word merge: define DCACHE_BRIDGE_MERGE_EN.
module dcache_uncached_bridge
    import dcache_uncached_bridge_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = TagWidth,
    parameter int unsigned INDEX_WIDTH  = IndexWidth,
    parameter int unsigned OFFSET_WIDTH = OffsetWidth
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_valid,
    input  logic                    p1_valid,
    input  logic [2:0]              op,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] p0_offset,
    input  logic [OFFSET_WIDTH-1:0] p1_offset,
    input  logic [3:0]              p0_wstrb,
    input  logic [3:0]              p1_wstrb,
    input  logic [31:0]             p0_wdata,
    input  logic [31:0]             p1_wdata,
    input  logic [1:0]              p0_size,
    input  logic [1:0]              p1_size,
    input  logic                    uncached,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [31:0]             p0_rdata,
    output logic [31:0]             p1_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [1:0]              mem_size,
    output logic [3:0]              mem_wstrb,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    input  logic [31:0]             mem_rdata
);

    dcache_bridge_state_t state_q;
    mem_slot_t            slot0_q, slot1_q, slot0_d, slot1_d, active;
    logic                 has_p1_q;
    logic                 merge;
    logic                 sel;

    // Only the write/read bit of op and none of uncached steer this block.
    logic unused_inputs;
    assign unused_inputs = ^{uncached, op[2:1]};

    assign slot0_d = '{we:    op[0],
                       addr:  {tag, index, p0_offset},
                       size:  p0_size,
                       wstrb: p0_wstrb,
                       wdata: p0_wdata};
    assign slot1_d = '{we:    op[0],
                       addr:  {tag, index, p1_offset},
                       size:  p1_size,
                       wstrb: p1_wstrb,
                       wdata: p1_wdata};

    assign sel = (state_q == StReq1) || (state_q == StWait1);

    dcache_bridge_slot_sel u_slot_sel (
        .slot0  (slot0_q),
        .slot1  (slot1_q),
        .has_p1 (has_p1_q),
        .sel    (sel),
        .active (active),
        .merge  (merge)
    );

    // Gated by reset so the upstream never sees a ready slot during reset.
    assign addr_ok   = reset && (state_q == StIdle);
    assign data_ok   = (state_q == StDone);
    assign mem_req   = (state_q == StReq0) || (state_q == StReq1);
    assign mem_we    = active.we;
    assign mem_addr  = active.addr;
    assign mem_size  = active.size;
    assign mem_wstrb = active.wstrb;
    assign mem_wdata = active.wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            slot0_q  <= '0;
            slot1_q  <= '0;
            has_p1_q <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (p0_valid && addr_ok) begin
                        slot0_q  <= slot0_d;
                        slot1_q  <= slot1_d;
                        has_p1_q <= p1_valid;
                        state_q  <= StReq0;
                    end
                end
                StReq0: begin
                    if (mem_addr_ok) state_q <= StWait0;
                end
                StWait0: begin
                    if (mem_data_ok) begin
                        if (!slot0_q.we) begin
                            p0_rdata <= mem_rdata;
                            if (merge) p1_rdata <= mem_rdata;
                        end
                        state_q <= (has_p1_q && !merge) ? StReq1 : StDone;
                    end
                end
                StReq1: begin
                    if (mem_addr_ok) state_q <= StWait1;
                end
                StWait1: begin
                    if (mem_data_ok) begin
                        if (!slot1_q.we) p1_rdata <= mem_rdata;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_uncached_bridge.sv
// Self-checking bench for dcache_uncached_bridge: directed scenarios plus randomized pairs
// against a transaction-level model and a behavioural memory responder.
module tb_dcache_uncached_bridge;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } tx_t;

    logic        clk, reset;
    logic        p0_valid, p1_valid, uncached;
    logic [2:0]  op;
    logic [19:0] tag;
    logic [5:0]  index, p0_offset, p1_offset;
    logic [3:0]  p0_wstrb, p1_wstrb, mem_wstrb;
    logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  p0_size, p1_size, mem_size;
    logic        addr_ok, data_ok, mem_req, mem_we, mem_addr_ok, mem_data_ok;

    int n_checks = 0;
    int n_errors = 0;

    // Memory responder state
    logic [31:0] mem_words [logic [29:0]];
    tx_t         txq[$];
    tx_t         prev_tx;
    bit          prev_stalled = 0;
    bit          pend = 0;
    bit          rand_mode = 0;
    int          resp_cnt = 0;
    int          lat_cfg = 0;
    int          stall_left = 0;
    int          stalls_seen = 0;
    logic [31:0] resp_data;
    logic [31:0] exp_p0 = '0;
    logic [31:0] exp_p1 = '0;

    dcache_uncached_bridge dut (
        .clk         (clk),
        .reset       (reset),
        .p0_valid    (p0_valid),
        .p1_valid    (p1_valid),
        .op          (op),
        .tag         (tag),
        .index       (index),
        .p0_offset   (p0_offset),
        .p1_offset   (p1_offset),
        .p0_wstrb    (p0_wstrb),
        .p1_wstrb    (p1_wstrb),
        .p0_wdata    (p0_wdata),
        .p1_wdata    (p1_wdata),
        .p0_size     (p0_size),
        .p1_size     (p1_size),
        .uncached    (uncached),
        .addr_ok     (addr_ok),
        .data_ok     (data_ok),
        .p0_rdata    (p0_rdata),
        .p1_rdata    (p1_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (mem_words.exists(w)) return mem_words[w];
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Memory: accepts after stall_left cycles, answers after a latency, never in the accept cycle.
    always @(negedge clk) begin
        tx_t         cur;
        logic [31:0] w;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom;
        if (!reset) begin
            pend         = 1'b0;
            prev_stalled = 1'b0;
        end else if (pend) begin
            if (resp_cnt == 0) begin
                mem_data_ok = 1'b1;
                mem_rdata   = resp_data;
                pend        = 1'b0;
            end else begin
                resp_cnt--;
            end
        end else if (mem_req === 1'b1) begin
            cur = '{we: mem_we, addr: mem_addr, size: mem_size, wstrb: mem_wstrb,
                    wdata: mem_wdata};
            if (prev_stalled) begin
                n_checks++;
                if (cur !== prev_tx) begin
                    n_errors++;
                    $display("FAIL stable_fields: got %h required %h", cur, prev_tx);
                end
            end
            if (stall_left > 0) begin
                stall_left--;
                stalls_seen++;
                prev_stalled = 1'b1;
                prev_tx      = cur;
            end else begin
                mem_addr_ok  = 1'b1;
                prev_stalled = 1'b0;
                txq.push_back(cur);
                if (cur.we) begin
                    w = mem_rd(cur.addr[31:2]);
                    for (int b = 0; b < 4; b++)
                        if (cur.wstrb[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
                    mem_words[cur.addr[31:2]] = w;
                    resp_data = $urandom;
                end else begin
                    resp_data = mem_rd(cur.addr[31:2]);
                end
                pend     = 1'b1;
                resp_cnt = rand_mode ? int'($urandom_range(0, 3)) : lat_cfg;
                if (rand_mode) stall_left = $urandom_range(0, 3);
            end
        end
    end

    task automatic scramble_inputs();
        p0_valid  = 1'b0;
        p1_valid  = 1'b0;
        op        = 3'($urandom);
        tag       = 20'($urandom);
        index     = 6'($urandom);
        p0_offset = 6'($urandom);
        p1_offset = 6'($urandom);
        p0_wstrb  = 4'($urandom);
        p1_wstrb  = 4'($urandom);
        p0_wdata  = $urandom;
        p1_wdata  = $urandom;
        p0_size   = 2'($urandom);
        p1_size   = 2'($urandom);
        uncached  = 1'($urandom);
    endtask

    // Issues one request at the next falling edge and checks the whole pair.
    task automatic do_pair(input bit p1v, input bit we, input logic [19:0] t,
                           input logic [5:0] ix, input logic [5:0] o0, input logic [5:0] o1,
                           input logic [3:0] ws0, input logic [3:0] ws1,
                           input logic [31:0] wd0, input logic [31:0] wd1,
                           input logic [1:0] sz0, input logic [1:0] sz1, input bit check_lat);
        tx_t         exp[$];
        tx_t         e;
        logic [31:0] a0, a1, m;
        bit          mrg, aok_bad;
        int          cyc;
        a0  = {t, ix, o0};
        a1  = {t, ix, o1};
        mrg = 1'b0;
`ifdef DCACHE_BRIDGE_MERGE_EN
        mrg = p1v && (a0[31:2] == a1[31:2]);
`endif
        if (mrg && we) begin
            for (int b = 0; b < 4; b++) m[8*b +: 8] = ws1[b] ? wd1[8*b +: 8] : wd0[8*b +: 8];
            exp.push_back('{we: 1'b1, addr: a0, size: 2'd2, wstrb: ws0 | ws1, wdata: m});
        end else begin
            exp.push_back('{we: we, addr: a0, size: sz0, wstrb: ws0, wdata: wd0});
        end
        if (p1v && !mrg) exp.push_back('{we: we, addr: a1, size: sz1, wstrb: ws1, wdata: wd1});
        if (!we) begin
            exp_p0 = mem_rd(a0[31:2]);
            if (mrg)      exp_p1 = exp_p0;
            else if (p1v) exp_p1 = mem_rd(a1[31:2]);
        end

        @(negedge clk);
        n_checks++;
        if (addr_ok !== 1'b1 || data_ok !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_ready: addr_ok=%b data_ok=%b required 1/0", addr_ok, data_ok);
        end
        p0_valid = 1'b1; p1_valid = p1v; op = {2'($urandom), we};
        tag = t; index = ix; p0_offset = o0; p1_offset = o1;
        p0_wstrb = ws0; p1_wstrb = ws1; p0_wdata = wd0; p1_wdata = wd1;
        p0_size = sz0; p1_size = sz1; uncached = 1'($urandom);
        @(negedge clk);
        scramble_inputs();
        cyc     = 1;
        aok_bad = 1'b0;
        while (data_ok !== 1'b1 && cyc < 300) begin
            if (addr_ok !== 1'b0) aok_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (addr_ok !== 1'b0) aok_bad = 1'b1;
        n_checks++;
        if (data_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL data_ok_timeout: data_ok=%b after %0d cycles, required 1", data_ok, cyc);
        end
        n_checks++;
        if (aok_bad) begin
            n_errors++;
            $display("FAIL busy_addr_ok: addr_ok seen high while busy, required 0");
        end
        if (check_lat) begin
            n_checks++;
            if (cyc != (exp.size() == 1 ? 3 : 5)) begin
                n_errors++;
                $display("FAIL latency: got %0d cycles required %0d", cyc,
                         (exp.size() == 1 ? 3 : 5));
            end
        end
        n_checks++;
        if (txq.size() != exp.size()) begin
            n_errors++;
            $display("FAIL txn_count: got %0d required %0d", txq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                e = txq[i];
                n_checks++;
                if (e.we !== exp[i].we || e.addr !== exp[i].addr ||
                    ((we || !mrg) && e.size !== exp[i].size) ||
                    (we && (e.wstrb !== exp[i].wstrb || e.wdata !== exp[i].wdata))) begin
                    n_errors++;
                    $display("FAIL txn_%0d: got %h required %h", i, e, exp[i]);
                end
            end
        end
        n_checks++;
        if (p0_rdata !== exp_p0 || p1_rdata !== exp_p1) begin
            n_errors++;
            $display("FAIL rdata: got %h/%h required %h/%h", p0_rdata, p1_rdata, exp_p0, exp_p1);
        end
        txq.delete();
    endtask

    task automatic test_reset();
        scramble_inputs();
        reset = 1'b1;
        #3 reset = 1'b0;
        #4;
        n_checks++;
        if (addr_ok !== 0 || data_ok !== 0 || mem_req !== 0 || mem_we !== 0 ||
            mem_addr !== 0 || mem_wdata !== 0 || mem_wstrb !== 0 || mem_size !== 0 ||
            p0_rdata !== 0 || p1_rdata !== 0) begin
            n_errors++;
            $display("FAIL reset_outputs: addr_ok=%b data_ok=%b mem_req=%b addr=%h rdata=%h/%h required all 0",
                     addr_ok, data_ok, mem_req, mem_addr, p0_rdata, p1_rdata);
        end
        p0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        p0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (addr_ok !== 1'b1 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: addr_ok=%b mem_req=%b required 1/0", addr_ok, mem_req);
        end
    endtask

    task automatic test_single_read();
        mem_words[30'(32'h1C000040 >> 2)] = 32'hDEADBEEF;
        do_pair(1'b0, 1'b0, 20'h1C000, 6'h01, 6'h00, 6'h3F, 4'h0, 4'h0, 0, 0, 2'd2, 2'd2, 1'b1);
        n_checks++;
        if (p0_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL single_read: got %h required deadbeef", p0_rdata);
        end
    endtask

    task automatic test_pair_read();
        mem_words[30'(32'h1C000044 >> 2)] = 32'h11112222;
        mem_words[30'(32'h1C000050 >> 2)] = 32'h33334444;
        do_pair(1'b1, 1'b0, 20'h1C000, 6'h01, 6'h04, 6'h10, 4'h0, 4'h0, 0, 0, 2'd2, 2'd2, 1'b1);
        n_checks++;
        if (p0_rdata !== 32'h11112222 || p1_rdata !== 32'h33334444) begin
            n_errors++;
            $display("FAIL pair_read: got %h/%h required 11112222/33334444", p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_backpressure_write();
        int s0;
        s0         = stalls_seen;
        stall_left = 5;
        do_pair(1'b0, 1'b1, 20'hABCDE, 6'h12, 6'h08, 6'h00, 4'h3, 4'h0, $urandom, $urandom,
                2'd1, 2'd0, 1'b0);
        n_checks++;
        if (stalls_seen - s0 != 5) begin
            n_errors++;
            $display("FAIL backpressure_stalls: got %0d required 5", stalls_seen - s0);
        end
    endtask

    task automatic test_reset_wait1();
        int cyc;
        lat_cfg = 40;
        @(negedge clk);
        p0_valid = 1'b1; p1_valid = 1'b1; op = 3'b000; tag = 20'h22222; index = 6'h3;
        p0_offset = 6'h00; p1_offset = 6'h20; p0_size = 2'd2; p1_size = 2'd2;
        @(negedge clk);
        scramble_inputs();
        cyc = 0;
        while (txq.size() < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (txq.size() != 2) begin
            n_errors++;
            $display("FAIL reach_wait1: got %0d txns required 2", txq.size());
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (addr_ok !== 0 || data_ok !== 0 || mem_req !== 0 || mem_addr !== 0 ||
            p0_rdata !== 0 || p1_rdata !== 0) begin
            n_errors++;
            $display("FAIL abort_clear: addr_ok=%b data_ok=%b mem_req=%b addr=%h rdata=%h/%h required 0",
                     addr_ok, data_ok, mem_req, mem_addr, p0_rdata, p1_rdata);
        end
        exp_p0 = '0;
        exp_p1 = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        lat_cfg = 0;
        @(negedge clk);
        n_checks++;
        if (addr_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_ready: addr_ok=%b required 1", addr_ok);
        end
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (data_ok !== 1'b0 || mem_req !== 1'b0) cyc++;
        end
        n_checks++;
        if (cyc != 0) begin
            n_errors++;
            $display("FAIL abort_silent: %0d cycles with data_ok/mem_req, required 0", cyc);
        end
        txq.delete();
    endtask

    task automatic test_merge();
        do_pair(1'b1, 1'b1, 20'h1C001, 6'h02, 6'h20, 6'h22, 4'h1, 4'h4, 32'h000000AA,
                32'h00CC0000, 2'd0, 2'd0, 1'b1);
        do_pair(1'b0, 1'b0, 20'h1C001, 6'h02, 6'h20, 6'h00, 4'h0, 4'h0, 0, 0, 2'd2, 2'd2, 1'b1);
        n_checks++;
        if ((p0_rdata & 32'h00FF00FF) !== 32'h00CC00AA) begin
            n_errors++;
            $display("FAIL merge_word: got %h required xxCCxxAA", p0_rdata);
        end
        do_pair(1'b1, 1'b0, 20'h1C001, 6'h02, 6'h08, 6'h0A, 4'h0, 4'h0, 0, 0, 2'd2, 2'd1, 1'b1);
    endtask

    task automatic test_illegal_and_back_to_back();
        int bad;
        bad = 0;
        @(negedge clk);
        p0_valid = 1'b0;
        p1_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || addr_ok !== 1'b1) bad++;
        end
        p1_valid = 1'b0;
        @(negedge clk);
        if (mem_req !== 1'b0 || addr_ok !== 1'b1) bad++;
        n_checks++;
        if (bad != 0 || txq.size() != 0) begin
            n_errors++;
            $display("FAIL p1_only_rejected: %0d bad cycles, %0d txns, required 0/0", bad, txq.size());
        end
        do_pair(1'b1, 1'b0, 20'h00F00, 6'h05, 6'h10, 6'h30, 4'h0, 4'h0, 0, 0, 2'd2, 2'd2, 1'b1);
        do_pair(1'b0, 1'b1, 20'h00F00, 6'h05, 6'h10, 6'h00, 4'hF, 4'h0, $urandom, 0,
                2'd2, 2'd0, 1'b1);
        do_pair(1'b1, 1'b0, 20'h00F00, 6'h05, 6'h10, 6'h14, 4'h0, 4'h0, 0, 0, 2'd2, 2'd2, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] o0, o1;
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            o0 = 6'($urandom);
            o1 = $urandom_range(0, 1) ? {o0[5:2], 2'($urandom)} : 6'($urandom);
            do_pair(1'($urandom), 1'($urandom), 20'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                    o0, o1, 4'($urandom), 4'($urandom), $urandom, $urandom,
                    2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'b0);
        end
        rand_mode  = 1'b0;
        stall_left = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_pair_read();
        test_backpressure_write();
        test_reset_wait1();
        test_merge();
        test_illegal_and_back_to_back();
        test_random();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
